// File: rtl/systolic_mac_array.sv
// Output-stationary max_dim x max_dim systolic MAC array; results leave one row per cycle.
// Optional MAC_SATURATE_EN: accumulators saturate instead of wrapping.
module systolic_mac_array #(
   parameter int unsigned data_width = 32,
   parameter int unsigned bus_width  = 64,
   localparam int unsigned max_dim   = bus_width / data_width,
   localparam int unsigned idx_w     = (max_dim > 1) ? $clog2(max_dim) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          in_valid,
   input  logic [max_dim*data_width-1:0] vectorA,
   input  logic [max_dim*data_width-1:0] vectorB,
   output logic [max_dim*data_width-1:0] result_row,
   output logic [idx_w-1:0]              result_idx,
   output logic                          result_valid,
   output logic                          done,
   output logic                          busy
);

   localparam int unsigned cnt_w = (3 * max_dim - 2 > 1) ? $clog2(3 * max_dim - 2) : 1;
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(3 * max_dim - 3);
   localparam logic [idx_w-1:0] idx_last = idx_w'(max_dim - 1);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StArmed   = 3'd1;
   localparam logic [2:0] StCompute = 3'd2;
   localparam logic [2:0] StOutput  = 3'd3;
   localparam logic [2:0] StDone    = 3'd4;

   logic [2:0]                    state_q, state_d;
   logic [cnt_w-1:0]              cnt_q, cnt_d;
   logic [idx_w-1:0]              idx_q, idx_d;
   logic [max_dim*data_width-1:0] row_q, row_d;
   logic                          valid_q, valid_d;
   logic                          done_q, done_d;
   logic                          clear;
   logic                          mac_en;

   logic [data_width-1:0] edge_a [max_dim];
   logic [data_width-1:0] edge_b [max_dim];
   logic [data_width-1:0] acc_w  [max_dim][max_dim];

   logic [idx_w-1:0]              row_sel;
   logic [max_dim*data_width-1:0] row_data;

   for (genvar k = 0; k < max_dim; k++) begin : g_edge
      assign edge_a[k] = in_valid ? vectorA[k*data_width +: data_width] : '0;
      assign edge_b[k] = in_valid ? vectorB[k*data_width +: data_width] : '0;
   end

   for (genvar i = 0; i < max_dim; i++) begin : g_row
      for (genvar j = 0; j < max_dim; j++) begin : g_col
         logic [data_width-1:0] a_in, b_in, acc_q, acc_next;

         if (j == 0) begin : g_a_edge
            assign a_in = edge_a[i];
         end else begin : g_a_fwd
            assign a_in = g_row[i].g_col[j-1].g_a_reg.a_q;
         end

         if (i == 0) begin : g_b_edge
            assign b_in = edge_b[j];
         end else begin : g_b_fwd
            assign b_in = g_row[i-1].g_col[j].g_b_reg.b_q;
         end

`ifdef MAC_SATURATE_EN
         logic [2*data_width-1:0] prod;
         logic [data_width:0]     sum;
         assign prod     = {{data_width{1'b0}}, a_in} * {{data_width{1'b0}}, b_in};
         assign sum      = {1'b0, acc_q} + {1'b0, prod[data_width-1:0]};
         assign acc_next = ((|prod[2*data_width-1:data_width]) || sum[data_width]) ?
                           '1 : sum[data_width-1:0];
`else
         logic [data_width-1:0] prod;
         assign prod     = a_in * b_in;
         assign acc_next = acc_q + prod;
`endif

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               acc_q <= '0;
            end else if (clear) begin
               acc_q <= '0;
            end else if (mac_en) begin
               acc_q <= acc_next;
            end
         end

         // The last column/row has no downstream neighbour, so no forwarding register.
         if (j < max_dim - 1) begin : g_a_reg
            logic [data_width-1:0] a_q;
            always_ff @(posedge clk or negedge reset) begin
               if (!reset) begin
                  a_q <= '0;
               end else if (clear) begin
                  a_q <= '0;
               end else if (mac_en) begin
                  a_q <= a_in;
               end
            end
         end

         if (i < max_dim - 1) begin : g_b_reg
            logic [data_width-1:0] b_q;
            always_ff @(posedge clk or negedge reset) begin
               if (!reset) begin
                  b_q <= '0;
               end else if (clear) begin
                  b_q <= '0;
               end else if (mac_en) begin
                  b_q <= b_in;
               end
            end
         end

         assign acc_w[i][j] = acc_q;
      end
   end

   // Row 0 is loaded on the COMPUTE exit edge, later rows while in OUTPUT.
   always_comb begin
      row_sel  = (state_q == StOutput) ? idx_q + 1'b1 : '0;
      row_data = '0;
      for (int r = 0; r < max_dim; r++) begin
         if (row_sel == idx_w'(r)) begin
            for (int c = 0; c < max_dim; c++) begin
               row_data[c*data_width +: data_width] = acc_w[r][c];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = '0;
      row_d   = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      clear   = 1'b0;
      mac_en  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StArmed;
               clear   = 1'b1;
            end
         end
         StArmed: begin
            if (in_valid) begin
               state_d = StCompute;
               cnt_d   = '0;
               mac_en  = 1'b1;
            end
         end
         StCompute: begin
            if (cnt_q == cnt_last) begin
               state_d = StOutput;
               valid_d = 1'b1;
               row_d   = row_data;
            end else begin
               cnt_d  = cnt_q + 1'b1;
               mac_en = 1'b1;
            end
         end
         StOutput: begin
            if (idx_q == idx_last) begin
               state_d = StDone;
               done_d  = 1'b1;
            end else begin
               idx_d   = idx_q + 1'b1;
               valid_d = 1'b1;
               row_d   = row_data;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign result_row   = row_q;
   assign result_idx   = idx_q;
   assign result_valid = valid_q;
   assign done         = done_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array at N=2, data_width=32.
// Honours MAC_SATURATE_EN for the overflow expectation.
module tb_systolic_mac_array;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [63:0] vectorA;
   logic [63:0] vectorB;
   logic [63:0] result_row;
   logic        result_idx;
   logic        result_valid;
   logic        done;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   systolic_mac_array #(
      .data_width(32),
      .bus_width (64)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .in_valid    (in_valid),
      .vectorA     (vectorA),
      .vectorB     (vectorB),
      .result_row  (result_row),
      .result_idx  (result_idx),
      .result_valid(result_valid),
      .done        (done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_outputs(input string tag);
      chk({tag, ":busy"}, {63'd0, busy}, 64'd0);
      chk({tag, ":valid"}, {63'd0, result_valid}, 64'd0);
      chk({tag, ":done"}, {63'd0, done}, 64'd0);
      chk({tag, ":row"}, result_row, 64'd0);
      chk({tag, ":idx"}, {63'd0, result_idx}, 64'd0);
   endtask

   // One full product: start, optional ARMED wait, 3 feed cycles, then output/done timing.
   task automatic run(input string tag,
                      input logic [63:0] va0, input logic [63:0] va1, input logic [63:0] va2,
                      input logic [63:0] vb0, input logic [63:0] vb1, input logic [63:0] vb2,
                      input logic [2:0] vmask, input int wait_cycles, input logic start_in_out,
                      input logic [63:0] r0, input logic [63:0] r1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, ":busy_after_start"}, {63'd0, busy}, 64'd1);
      for (int w = 0; w < wait_cycles; w++) begin
         in_valid = 1'b0;
         vectorA  = 64'h0000_0009_0000_0009;
         vectorB  = 64'h0000_0009_0000_0009;
         tick();
         chk({tag, ":armed_busy"}, {63'd0, busy}, 64'd1);
         chk({tag, ":armed_valid"}, {63'd0, result_valid}, 64'd0);
      end
      for (int t = 0; t < 3; t++) begin
         in_valid = vmask[t];
         case (t)
            0: begin vectorA = va0; vectorB = vb0; end
            1: begin vectorA = va1; vectorB = vb1; end
            default: begin vectorA = va2; vectorB = vb2; end
         endcase
         tick();
         chk({tag, ":feed_valid"}, {63'd0, result_valid}, 64'd0);
         chk({tag, ":feed_busy"}, {63'd0, busy}, 64'd1);
      end
      in_valid = 1'b0;
      vectorA  = '0;
      vectorB  = '0;
      tick();
      chk({tag, ":last_mac_valid"}, {63'd0, result_valid}, 64'd0);
      tick();
      chk({tag, ":row0_valid"}, {63'd0, result_valid}, 64'd1);
      chk({tag, ":row0_idx"}, {63'd0, result_idx}, 64'd0);
      chk({tag, ":row0"}, result_row, r0);
      start    = start_in_out;
      in_valid = 1'b1;
      vectorA  = '1;
      vectorB  = '1;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      vectorA  = '0;
      vectorB  = '0;
      chk({tag, ":row1_valid"}, {63'd0, result_valid}, 64'd1);
      chk({tag, ":row1_idx"}, {63'd0, result_idx}, 64'd1);
      chk({tag, ":row1"}, result_row, r1);
      chk({tag, ":done_early"}, {63'd0, done}, 64'd0);
      tick();
      chk({tag, ":done"}, {63'd0, done}, 64'd1);
      chk({tag, ":done_valid"}, {63'd0, result_valid}, 64'd0);
      chk({tag, ":done_row"}, result_row, 64'd0);
      chk({tag, ":done_busy"}, {63'd0, busy}, 64'd1);
      tick();
      chk({tag, ":done_drop"}, {63'd0, done}, 64'd0);
      chk({tag, ":idle_busy"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] wrap_exp;
`ifdef MAC_SATURATE_EN
      wrap_exp = 64'h0000_0000_FFFF_FFFF;
`else
      wrap_exp = 64'h0000_0000_FFFF_FFFE;
`endif
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      vectorA  = '0;
      vectorB  = '0;
      repeat (2) @(posedge clk);
      #1;
      idle_outputs("reset");

      // in_valid without start must not leave IDLE
      reset    = 1'b1;
      in_valid = 1'b1;
      vectorA  = 64'h0000_0003_0000_0001;
      vectorB  = 64'h0000_0006_0000_0005;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("no_start:busy", {63'd0, busy}, 64'd0);
         chk("no_start:valid", {63'd0, result_valid}, 64'd0);
      end
      in_valid = 1'b0;
      vectorA  = '0;
      vectorB  = '0;
      tick();

      run("basic", 64'h0000_0000_0000_0001, 64'h0000_0003_0000_0002, 64'h0000_0004_0000_0000,
          64'h0000_0000_0000_0005, 64'h0000_0006_0000_0007, 64'h0000_0008_0000_0000,
          3'b111, 1, 1'b0, {32'd22, 32'd19}, {32'd50, 32'd43});

      // Cycle-1 vectors present but in_valid low: A01, A10, B10, B01 all dropped
      run("gap", 64'h0000_0000_0000_0001, 64'h0000_0003_0000_0002, 64'h0000_0004_0000_0000,
          64'h0000_0000_0000_0005, 64'h0000_0006_0000_0007, 64'h0000_0008_0000_0000,
          3'b101, 0, 1'b0, {32'd0, 32'd5}, {32'd32, 32'd0});

      run("wrap", 64'h0000_0000_FFFF_FFFF, 64'd0, 64'd0,
          64'h0000_0000_0000_0002, 64'd0, 64'd0,
          3'b111, 0, 1'b0, wrap_exp, 64'd0);

      // Abort during compute cycle 2
      start = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      vectorA  = 64'h0000_0000_0000_0001;
      vectorB  = 64'h0000_0000_0000_0005;
      tick();
      vectorA  = 64'h0000_0003_0000_0002;
      vectorB  = 64'h0000_0006_0000_0007;
      tick();
      vectorA  = 64'h0000_0004_0000_0000;
      vectorB  = 64'h0000_0008_0000_0000;
      reset    = 1'b0;
      #1;
      idle_outputs("abort");
      in_valid = 1'b0;
      vectorA  = '0;
      vectorB  = '0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("abort:no_done", {63'd0, done}, 64'd0);
      end
      reset = 1'b1;
      tick();

      run("post_abort", 64'h0000_0000_0000_0001, 64'h0000_0003_0000_0002, 64'h0000_0004_0000_0000,
          64'h0000_0000_0000_0005, 64'h0000_0006_0000_0007, 64'h0000_0008_0000_0000,
          3'b111, 0, 1'b1, {32'd22, 32'd19}, {32'd50, 32'd43});

      run("identity", 64'h0000_0000_0000_0001, 64'd0, 64'h0000_0001_0000_0000,
          64'h0000_0000_0000_0005, 64'h0000_0006_0000_0007, 64'h0000_0008_0000_0000,
          3'b111, 0, 1'b0, {32'd6, 32'd5}, {32'd8, 32'd7});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
